dsp_xintf_w_ram_reader: RTL

DSP_XINTF_W_RAM_READER -- requirements
Module: dsp_xintf_w_ram_reader

---
 rtl/dsp_xintf_w_ram_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dsp_xintf_w_ram_reader.sv
// Copies a P_LEN-word frame out of the DSP-written DPBRAM into a
// valid/ready word stream, keeping a running 16-bit sum of words handed off.
module dsp_xintf_w_ram_reader #(
   parameter logic [8:0] P_BASE_ADDR = 9'h000,
   parameter int         P_LEN       = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_abort,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_aborted,
   output logic [15:0] o_sum,
   output logic [8:0]  o_xintf_w_ram_addr,
   output logic        o_xintf_w_ram_ce,
   output logic        o_xintf_w_ram_we,
   output logic [15:0] o_xintf_w_ram_din,
   input  logic [15:0] i_xintf_w_ram_dout,
   output logic [15:0] o_m_data,
   output logic [8:0]  o_m_index,
   output logic        o_m_valid,
   input  logic        i_m_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LAT,
      S_OUT,
      S_DONE
   } state_t;

   localparam logic [8:0] LAST = 9'(P_LEN - 1);

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [8:0]  addr_q, addr_d;
   logic        ce_q, ce_d;
   logic [15:0] data_q, data_d;
   logic [8:0]  idx_q, idx_d;
   logic        valid_q, valid_d;
   logic [15:0] sum_q, sum_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic        busy_q, busy_d;
   logic        hs;

   assign hs = valid_q & i_m_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      idx_d     = idx_q;
      sum_d     = sum_q;
      aborted_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               sum_d   = '0;
               cnt_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (i_abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else begin
               state_d = S_LAT;
            end
         end
         S_LAT: begin
            if (i_abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else begin
               data_d  = i_xintf_w_ram_dout;
               idx_d   = cnt_q;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            // a word accepted in the abort cycle still counts
            if (hs) begin
               sum_d = sum_q + data_q;
            end
            if (i_abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (hs) begin
               if (cnt_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q + 9'd1;
                  state_d = S_RD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ce_d = (state_d == S_RD);
      if (ce_d) begin
         addr_d = P_BASE_ADDR + cnt_d;
      end
      valid_d = (state_d == S_OUT);
      done_d  = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         ce_q      <= 1'b0;
         data_q    <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         sum_q     <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         ce_q      <= ce_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         sum_q     <= sum_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         busy_q    <= busy_d;
      end
   end

   assign o_busy             = busy_q;
   assign o_done             = done_q;
   assign o_aborted          = aborted_q;
   assign o_sum              = sum_q;
   assign o_xintf_w_ram_addr = addr_q;
   assign o_xintf_w_ram_ce   = ce_q;
   assign o_xintf_w_ram_we   = 1'b0;
   assign o_xintf_w_ram_din  = '0;
   assign o_m_data           = data_q;
   assign o_m_index          = idx_q;
   assign o_m_valid          = valid_q;

endmodule
